// File: rtl/data_memory_hs.sv
// Data memory with a valid/ready request and response handshake.
// Supports B/H/W loads and stores, a configurable response delay, and fault reporting.
//
// Ports:
//   CLK, RST    : clock; synchronous active-high reset
//   req_*       : request handshake (req_we, address, dataWr, dmCtrl)
//   rsp_*       : response handshake (dataRd, fault)
module data_memory_hs #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] address,
  input  logic [31:0] dataWr,
  input  logic [2:0]  dmCtrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] dataRd,
  output logic        fault
);

  localparam int IDX_W =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
  } req_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  req_t        in_req;
  req_t        cur;
  logic        accept;
  logic        commit;

  logic        is_b, is_h, is_w, is_bu, is_hu;
  logic [1:0]  off;
  logic [IDX_W-1:0] idx;
  logic        out_of_range;
  logic        misalign;
  logic        illegal;
  logic        flt;
  logic [3:0]  be;
  logic [31:0] wdat;
  logic [31:0] rd_word;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ld;

  assign req_ready = (state_q == S_IDLE) && !RST;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign dataRd    = rdata_q;
  assign fault     = fault_q;

  assign in_req = '{
    we:    req_we,
    addr:  address,
    wdata: dataWr,
    ctrl:  dmCtrl
  };

  // With no wait states the commit happens on the
  // acceptance edge itself, so the datapath must see
  // the live inputs rather than the captured copy.
  assign cur = (state_q == S_IDLE) ? in_req : req_q;

  assign off   = cur.addr[1:0];
  assign idx   = cur.addr[IDX_W+1:2];
  assign is_b  = (cur.ctrl == 3'b000);
  assign is_h  = (cur.ctrl == 3'b001);
  assign is_w  = (cur.ctrl == 3'b010);
  assign is_bu = (cur.ctrl == 3'b100);
  assign is_hu = (cur.ctrl == 3'b101);

  // Full word-index compare so upper address bits
  // fault instead of aliasing onto low entries.
  assign out_of_range =
    {2'b00, cur.addr[31:2]} >= 32'(DEPTH_WORDS);

  assign rd_word = out_of_range ? 32'h0 : mem_q[idx];
  assign bsel    = rd_word[8*off +: 8];
  assign hsel    = off[1] ? rd_word[31:16]
                          : rd_word[15:0];

  always_comb begin
    be       = 4'b0000;
    wdat     = 32'h0;
    ld       = 32'h0;
    misalign = 1'b0;
    illegal  = 1'b0;
    unique case (1'b1)
      is_b, is_bu: begin
        be   = 4'b0001 << off;
        wdat = {4{cur.wdata[7:0]}};
        ld   = is_b ? {{24{bsel[7]}}, bsel}
                    : {24'h0, bsel};
      end
      is_h, is_hu: begin
        be       = off[1] ? 4'b1100 : 4'b0011;
        wdat     = {2{cur.wdata[15:0]}};
        ld       = is_h ? {{16{hsel[15]}}, hsel}
                        : {16'h0, hsel};
        misalign = off[0];
      end
      is_w: begin
        be       = 4'b1111;
        wdat     = cur.wdata;
        ld       = rd_word;
        misalign = (off != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign flt = illegal | misalign | out_of_range
             | (cur.we & (is_bu | is_hu));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    commit      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_d = in_req;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // Data is registered on entry; valid follows
        // one cycle later and holds until taken.
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      fault_d = flt;
      rdata_d = (flt || cur.we) ? 32'h0 : ld;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
    end
  end

  // Storage is never cleared; reset only blocks
  // a write that would land on the same edge.
  always_ff @(posedge CLK) begin
    if (!RST && commit && cur.we && !flt) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdat[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs with WAIT_STATES=2.
// Checks handshake timing, lane formatting, faults and reset.
module tb_data_memory_hs;

  localparam int WS  = 2;
  localparam int LAT = WS + 1;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] address;
  logic [31:0] dataWr;
  logic [2:0]  dmCtrl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] dataRd;
  logic        fault;

  int vectors;
  int miscompares;

  data_memory_hs #(
    .DEPTH_WORDS(256),
    .WAIT_STATES(WS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .address   (address),
    .dataWr    (dataWr),
    .dmCtrl    (dmCtrl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .dataRd    (dataRd),
    .fault     (fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge that
  // follows the acceptance edge.
  task automatic send(input logic we,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [2:0] c);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    address   = a;
    dataWr    = d;
    dmCtrl    = c;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("send_ready", {31'b0, req_ready}, 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    address   = $urandom;
    dataWr    = $urandom;
    dmCtrl    = 3'($urandom);
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
  endtask

  task automatic collect(input string tag,
                         input logic [31:0] exp_d,
                         input logic exp_f);
    wait_rsp(tag);
    chk({tag, "_data"}, dataRd, exp_d);
    chk({tag, "_fault"}, {31'b0, fault}, {31'b0, exp_f});
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk({tag, "_done"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic op(input string tag,
                    input logic we,
                    input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [2:0] c,
                    input logic [31:0] exp_d,
                    input logic exp_f);
    send(we, a, d, c);
    collect(tag, exp_d, exp_f);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    address   = 32'h0;
    dataWr    = 32'h0;
    dmCtrl    = 3'b000;
    rsp_ready = 1'b0;

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_dataRd", dataRd, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    RST = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge CLK);

    // 1: word store / load with latency
    op("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010,
       32'h0, 1'b0);
    op("lw10", 1'b0, 32'h10, 32'h0, 3'b010,
       32'hDEADBEEF, 1'b0);

    // 2: byte lanes
    op("sb11", 1'b1, 32'h11, 32'h000000AA, 3'b000,
       32'h0, 1'b0);
    op("lw10_b", 1'b0, 32'h10, 32'h0, 3'b010,
       32'hDEADAAEF, 1'b0);
    op("lb11", 1'b0, 32'h11, 32'h0, 3'b000,
       32'hFFFFFFAA, 1'b0);
    op("lbu11", 1'b0, 32'h11, 32'h0, 3'b100,
       32'h000000AA, 1'b0);
    op("lb10", 1'b0, 32'h10, 32'h0, 3'b000,
       32'hFFFFFFEF, 1'b0);

    // 3: half lanes and misalignment
    op("sh12", 1'b1, 32'h12, 32'h00001234, 3'b001,
       32'h0, 1'b0);
    op("lw10_h", 1'b0, 32'h10, 32'h0, 3'b010,
       32'h1234AAEF, 1'b0);
    op("lh12", 1'b0, 32'h12, 32'h0, 3'b001,
       32'h00001234, 1'b0);
    op("lh10", 1'b0, 32'h10, 32'h0, 3'b001,
       32'hFFFFAAEF, 1'b0);
    op("lhu10", 1'b0, 32'h10, 32'h0, 3'b101,
       32'h0000AAEF, 1'b0);
    op("lb13", 1'b0, 32'h13, 32'h0, 3'b000,
       32'h00000012, 1'b0);
    op("lh13", 1'b0, 32'h13, 32'h0, 3'b001,
       32'h0, 1'b1);
    op("lw12", 1'b0, 32'h12, 32'h0, 3'b010,
       32'h0, 1'b1);
    op("sh13", 1'b1, 32'h13, 32'h0000FFFF, 3'b001,
       32'h0, 1'b1);
    op("sw11", 1'b1, 32'h11, 32'h00000000, 3'b010,
       32'h0, 1'b1);
    op("lw10_kept", 1'b0, 32'h10, 32'h0, 3'b010,
       32'h1234AAEF, 1'b0);

    // 4: response backpressure
    send(1'b0, 32'h10, 32'h0, 3'b010);
    wait_rsp("bp");
    req_valid = 1'b1;
    req_we    = 1'b1;
    address   = 32'h14;
    dataWr    = 32'h55667788;
    dmCtrl    = 3'b010;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_data", dataRd, 32'h1234AAEF);
      chk("bp_fault", {31'b0, fault}, 32'd0);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge CLK);
    end
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk("bp_released", {31'b0, rsp_valid}, 32'd0);
    chk("bp_ready_again", {31'b0, req_ready}, 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("bp2_busy", {31'b0, req_ready}, 32'd0);
    collect("bp2", 32'h0, 1'b0);
    op("lw14", 1'b0, 32'h14, 32'h0, 3'b010,
       32'h55667788, 1'b0);

    // 5: range and illegal encodings
    op("sw0", 1'b1, 32'h0, 32'h0BADF00D, 3'b010,
       32'h0, 1'b0);
    op("sw400", 1'b1, 32'h400, 32'h11111111, 3'b010,
       32'h0, 1'b1);
    op("lw0", 1'b0, 32'h0, 32'h0, 3'b010,
       32'h0BADF00D, 1'b0);
    op("lw400", 1'b0, 32'h400, 32'h0, 3'b010,
       32'h0, 1'b1);
    op("sw_hi", 1'b1, 32'h8000_0000, 32'h22222222,
       3'b010, 32'h0, 1'b1);
    op("sw3fc", 1'b1, 32'h3FC, 32'hA5A5A5A5, 3'b010,
       32'h0, 1'b0);
    op("lb3ff", 1'b0, 32'h3FF, 32'h0, 3'b000,
       32'hFFFFFFA5, 1'b0);
    op("ld011", 1'b0, 32'h10, 32'h0, 3'b011,
       32'h0, 1'b1);
    op("ld110", 1'b0, 32'h10, 32'h0, 3'b110,
       32'h0, 1'b1);
    op("ld111", 1'b0, 32'h10, 32'h0, 3'b111,
       32'h0, 1'b1);
    op("st100", 1'b1, 32'h0, 32'hFFFFFFFF, 3'b100,
       32'h0, 1'b1);
    op("st101", 1'b1, 32'h0, 32'hFFFFFFFF, 3'b101,
       32'h0, 1'b1);
    op("lw0_kept", 1'b0, 32'h0, 32'h0, 3'b010,
       32'h0BADF00D, 1'b0);

    // 6: reset during WAIT
    op("sw20", 1'b1, 32'h20, 32'h13579BDF, 3'b010,
       32'h0, 1'b0);
    send(1'b1, 32'h20, 32'hCAFEF00D, 3'b010);
    RST = 1'b1;
    @(negedge CLK);
    chk("rstw_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rstw_ready", {31'b0, req_ready}, 32'd0);
    RST = 1'b0;
    #1;
    chk("rstw_ready_up", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("rstw_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    op("lw20_a", 1'b0, 32'h20, 32'h0, 3'b010,
       32'h13579BDF, 1'b0);

    // reset on the commit edge
    send(1'b1, 32'h20, 32'hCAFEF00D, 3'b010);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rstc_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rstc_ready", {31'b0, req_ready}, 32'd1);
    @(negedge CLK);
    op("lw20_b", 1'b0, 32'h20, 32'h0, 3'b010,
       32'h13579BDF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
